// File: rtl/fio_host_pkg.sv
// fio_host_pkg: opcodes, header field positions and FSM states for the FileIO host controller.
package fio_host_pkg;
  localparam logic [3:0] OP_TM = 4'd1, OP_IC = 4'd2, OP_MEM = 4'd3, OP_CLE = 4'd4,
                         OP_RUN = 4'd5, OP_DUMP = 4'd6, OP_CLEAR = 4'd7;
  localparam int HDR_OP_LO = 28, HDR_BASE_LO = 16, HDR_BASE_W = 12, HDR_CNT_W = 16;
  typedef enum logic [3:0] {
    IDLE, LOAD_TM, LOAD_IC, LOAD_MEM, LOAD_CLE, RUN, DUMP_ADDR, DUMP_WAIT, DUMP_TX
  } state_t;
endpackage

// File: rtl/fio_line_serdes.sv
// fio_line_serdes: 8x32 <-> 256 line packer/unpacker sharing one shift register and word counter.
module fio_line_serdes (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [31:0]  word_in,
  input  logic         load,
  input  logic [255:0] line_in,
  input  logic         shift,
  output logic [255:0] packed_line,
  output logic [31:0]  word_out,
  output logic         last
);
  logic [255:0] line;
  logic [2:0]   cnt;
  // New words enter at the top so the first word ends up in [31:0] after eight pushes.
  assign packed_line = {word_in, line[255:32]};
  assign word_out = line[31:0];
  assign last = cnt == 3'd7;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      line <= '0;
      cnt <= '0;
    end else if (clr || load) begin
      cnt <= '0;
      if (load) line <= line_in;
    end else if (push) begin
      line <= packed_line;
      cnt <= cnt + 3'd1;
    end else if (shift) begin
      line <= {32'b0, line[255:32]};
      cnt <= cnt + 3'd1;
    end
endmodule

// File: rtl/fio_host_ctrl.sv
// fio_host_ctrl: host word stream to GPU FileIO loader, kernel launcher and MEM dumper.
module fio_host_ctrl
  import fio_host_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int SHMEM_DEPTH = 256,
  parameter int MEM_AW      = $clog2(MEM_DEPTH + SHMEM_DEPTH),
  parameter int CLE_AW      = $clog2(MEM_DEPTH),
  parameter int IC_AW       = 10,
  parameter int MEM_RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [31:0]       m_data,
  input  logic              m_ready,
  output logic              Wen_FIO_TM,
  output logic [28:0]       Din_FIO_TM,
  output logic              start_FIO_TM,
  output logic              clear_FIO_TM,
  input  logic              finished_TM_FIO,
  output logic              Wen_FIO_ICache,
  output logic [IC_AW-1:0]  Addr_FIO_ICache,
  output logic [31:0]       Din_FIO_ICache,
  output logic              Wen_FIO_MEM,
  output logic [MEM_AW-1:0] Addr_FIO_MEM,
  output logic [255:0]      Din_FIO_MEM,
  input  logic [255:0]      Dout_FIO_MEM,
  output logic              Wen_FIO_CLE,
  output logic [CLE_AW-1:0] Addr_FIO_CLE,
  output logic [4:0]        Din_FIO_CLE,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t                state;
  logic [HDR_CNT_W-1:0]  cnt;
  logic [3:0]            wcnt;
  logic [3:0]            op;
  logic [HDR_BASE_W-1:0] base;
  logic [HDR_CNT_W-1:0]  hcnt;
  logic [255:0]          mem_line;
  logic [31:0]           tx_word;
  logic                  line_last, wait_done;
  assign op = s_data[HDR_OP_LO +: 4];
  assign base = s_data[HDR_BASE_LO +: HDR_BASE_W];
  assign hcnt = s_data[HDR_CNT_W-1:0];
  assign s_ready = state inside {IDLE, LOAD_TM, LOAD_IC, LOAD_MEM, LOAD_CLE};
  assign busy = state != IDLE;
  assign m_valid = state == DUMP_TX;
  assign m_data = m_valid ? tx_word : '0;
  assign wait_done = wcnt == 4'(MEM_RD_LAT - 1);
  fio_line_serdes u_serdes (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE),
    .push(state == LOAD_MEM && s_valid),
    .word_in(s_data),
    .load(state == DUMP_WAIT && wait_done),
    .line_in(Dout_FIO_MEM),
    .shift(m_valid && m_ready),
    .packed_line(mem_line),
    .word_out(tx_word),
    .last(line_last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      wcnt <= '0;
      Wen_FIO_TM <= 1'b0;
      Din_FIO_TM <= '0;
      start_FIO_TM <= 1'b0;
      clear_FIO_TM <= 1'b0;
      Wen_FIO_ICache <= 1'b0;
      Addr_FIO_ICache <= '0;
      Din_FIO_ICache <= '0;
      Wen_FIO_MEM <= 1'b0;
      Addr_FIO_MEM <= '0;
      Din_FIO_MEM <= '0;
      Wen_FIO_CLE <= 1'b0;
      Addr_FIO_CLE <= '0;
      Din_FIO_CLE <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      Wen_FIO_TM <= 1'b0;
      Wen_FIO_ICache <= 1'b0;
      Wen_FIO_MEM <= 1'b0;
      Wen_FIO_CLE <= 1'b0;
      done <= 1'b0;
      clear_FIO_TM <= 1'b0;
      // Addresses step after each write; a header arriving on that same edge overrides below.
      if (Wen_FIO_ICache) Addr_FIO_ICache <= Addr_FIO_ICache + 1'b1;
      if (Wen_FIO_MEM) Addr_FIO_MEM <= Addr_FIO_MEM + 1'b1;
      if (Wen_FIO_CLE) Addr_FIO_CLE <= Addr_FIO_CLE + 1'b1;
      case (state)
        IDLE: if (s_valid) begin
          cnt <= hcnt;
          case (op)
            OP_TM: if (hcnt != 0) state <= LOAD_TM;
            OP_IC: if (hcnt != 0) begin
              Addr_FIO_ICache <= base[IC_AW-1:0];
              state <= LOAD_IC;
            end
            OP_MEM: if (hcnt != 0) begin
              Addr_FIO_MEM <= base[MEM_AW-1:0];
              state <= LOAD_MEM;
            end
            OP_CLE: if (hcnt != 0) begin
              Addr_FIO_CLE <= base[CLE_AW-1:0];
              state <= LOAD_CLE;
            end
            OP_RUN: begin
              start_FIO_TM <= 1'b1;
              state <= RUN;
            end
            OP_DUMP: if (hcnt != 0) begin
              Addr_FIO_MEM <= base[MEM_AW-1:0];
              state <= DUMP_ADDR;
            end
            OP_CLEAR: clear_FIO_TM <= 1'b1;
            default: err <= 1'b1;
          endcase
        end
        LOAD_TM: if (s_valid) begin
          Wen_FIO_TM <= 1'b1;
          Din_FIO_TM <= s_data[28:0];
          cnt <= cnt - 1'b1;
          if (cnt == 1) state <= IDLE;
        end
        LOAD_IC: if (s_valid) begin
          Wen_FIO_ICache <= 1'b1;
          Din_FIO_ICache <= s_data;
          cnt <= cnt - 1'b1;
          if (cnt == 1) state <= IDLE;
        end
        LOAD_CLE: if (s_valid) begin
          Wen_FIO_CLE <= 1'b1;
          Din_FIO_CLE <= s_data[4:0];
          cnt <= cnt - 1'b1;
          if (cnt == 1) state <= IDLE;
        end
        LOAD_MEM: if (s_valid && line_last) begin
          Wen_FIO_MEM <= 1'b1;
          Din_FIO_MEM <= mem_line;
          cnt <= cnt - 1'b1;
          if (cnt == 1) state <= IDLE;
        end
        RUN: if (finished_TM_FIO) begin
          start_FIO_TM <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end
        DUMP_ADDR: begin
          wcnt <= '0;
          state <= DUMP_WAIT;
        end
        DUMP_WAIT: begin
          wcnt <= wcnt + 4'd1;
          if (wait_done) state <= DUMP_TX;
        end
        DUMP_TX: if (m_ready && line_last) begin
          cnt <= cnt - 1'b1;
          if (cnt == 1) begin
            done <= 1'b1;
            state <= IDLE;
          end else begin
            Addr_FIO_MEM <= Addr_FIO_MEM + 1'b1;
            state <= DUMP_ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
